// File: rtl/video_timing_pkg.sv
// Shared constants, flag payload type and elaboration helpers for the raster timing generator.
package video_timing_pkg;

  // 1080p60 (CEA-861 VIC 16)
  localparam int unsigned H_ACTIVE_1080P60 = 1920;
  localparam int unsigned H_FP_1080P60     = 88;
  localparam int unsigned H_SYNC_1080P60   = 44;
  localparam int unsigned H_BP_1080P60     = 148;
  localparam int unsigned V_ACTIVE_1080P60 = 1080;
  localparam int unsigned V_FP_1080P60     = 4;
  localparam int unsigned V_SYNC_1080P60   = 5;
  localparam int unsigned V_BP_1080P60     = 36;

  // 720p60 (CEA-861 VIC 4)
  localparam int unsigned H_ACTIVE_720P60  = 1280;
  localparam int unsigned H_FP_720P60      = 110;
  localparam int unsigned H_SYNC_720P60    = 40;
  localparam int unsigned H_BP_720P60      = 220;
  localparam int unsigned V_ACTIVE_720P60  = 720;
  localparam int unsigned V_FP_720P60      = 5;
  localparam int unsigned V_SYNC_720P60    = 5;
  localparam int unsigned V_BP_720P60      = 20;

  // Registered raster flags, loaded together with the position they describe.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } vt_flags_t;

  // Total period of one axis.
  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Ceiling log2, used to check counter widths at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 64'(1);
    while (p < 64'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// Enabled modulo counter: counts 0..MAX, wraps to 0, synchronous clear has priority.
module wrap_counter #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned MAX   = 2199
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  // Terminal count: the next enabled cycle returns to zero.
  assign wrap  = (count_q == WIDTH'(MAX));
  assign count = count_q;

  // Next count: clear beats increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y position plus DE, syncs and line/frame markers.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned X_W      = 12,
  parameter int unsigned Y_W      = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           resync,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (clog2(H_TOTAL) > X_W) begin : g_bad_x_w
    $error("video_timing_gen: X_W too narrow for H_TOTAL");
  end
  if (clog2(V_TOTAL) > Y_W) begin : g_bad_y_w
    $error("video_timing_gen: Y_W too narrow for V_TOTAL");
  end

  logic           clr;
  logic           v_en;
  logic           h_wrap;
  logic           v_wrap;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  vt_flags_t      flags_d, flags_q;

  assign clr  = resync & pix_en;
  assign v_en = pix_en & h_wrap;

  wrap_counter #(.WIDTH(X_W), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .clr   (clr),
    .count (x),
    .wrap  (h_wrap)
  );

  wrap_counter #(.WIDTH(Y_W), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .clr   (clr),
    .count (y),
    .wrap  (v_wrap)
  );

  // Position the counters will hold after this edge, so flags line up with it.
  always_comb begin
    x_d = x;
    y_d = y;
    if (reset || clr) begin
      x_d = '0;
      y_d = '0;
    end else if (pix_en) begin
      x_d = h_wrap ? '0 : x + X_W'(1);
      if (h_wrap) y_d = v_wrap ? '0 : y + Y_W'(1);
    end
  end

  // Decode the upcoming position into DE, syncs and markers.
  always_comb begin
    flags_d             = '0;
    flags_d.active      = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    flags_d.hsync       = ((32'(x_d) >= HS_START) && (32'(x_d) < HS_END)) ? HS_POL : ~HS_POL;
    flags_d.vsync       = ((32'(y_d) >= VS_START) && (32'(y_d) < VS_END)) ? VS_POL : ~VS_POL;
    flags_d.line_start  = (x_d == '0);
    flags_d.frame_start = (x_d == '0) && (y_d == '0);
  end

  // Flag register; reset reaches it through the (0,0) decode above.
  always_ff @(posedge clk) begin
    flags_q <= flags_d;
  end

  assign active      = flags_q.active;
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: small-mode DUT and default 1080p DUT checked every cycle against a raster model.
module tb_video_timing_gen;

  // Small mode: H 4/1/2/1 (8), V 3/1/1/1 (6), hsync active-low, vsync active-high.
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  // Default 1080p60 mode on the second instance.
  localparam int BHT = 2200, BVT = 1125;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic resync = 1'b0;

  logic [2:0]  ax_o, ay_o;
  logic        a_act, a_hs, a_vs, a_ls, a_fs;
  logic [11:0] bx_o;
  logic [10:0] by_o;
  logic        b_act, b_hs, b_vs, b_ls, b_fs;

  int n_vec = 0;
  int n_err = 0;

  int  mx = 0, my = 0, nx = 0, ny = 0;
  bit  model_ok = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .X_W(3), .Y_W(3)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en), .resync(resync),
    .x(ax_o), .y(ay_o), .active(a_act), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .resync(resync),
    .x(bx_o), .y(by_o), .active(b_act), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // Expected {active,hsync,vsync,line_start,frame_start} for a raster position.
  function automatic int decode(input int px, input int py,
                                input int ha, input int hf, input int hs,
                                input int va, input int vf, input int vs,
                                input bit hp, input bit vp);
    bit de, h, v, ls, fs;
    de = (px < ha) && (py < va);
    h  = (px >= ha + hf && px < ha + hf + hs) ? hp : !hp;
    v  = (py >= va + vf && py < va + vf + vs) ? vp : !vp;
    ls = (px == 0);
    fs = (px == 0) && (py == 0);
    return {27'd0, de, h, v, ls, fs};
  endfunction

  // Advance one pixel as a linear index into the frame.
  function automatic int adv_lin(input int px, input int py, input int ht, input int vt);
    return (py * ht + px + 1) % (ht * vt);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference raster: reset > resync (with pix_en) > advance > hold.
  always @(posedge clk) begin
    if (reset) begin
      mx <= 0; my <= 0; nx <= 0; ny <= 0;
      model_ok <= 1'b1;
    end else if (pix_en) begin
      if (resync) begin
        mx <= 0; my <= 0; nx <= 0; ny <= 0;
      end else begin
        mx <= adv_lin(mx, my, HT, VT) % HT;
        my <= adv_lin(mx, my, HT, VT) / HT;
        nx <= adv_lin(nx, ny, BHT, BVT) % BHT;
        ny <= adv_lin(nx, ny, BHT, BVT) / BHT;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_x", int'(ax_o), mx);
      chk("a_y", int'(ay_o), my);
      chk("a_flags", int'({a_act, a_hs, a_vs, a_ls, a_fs}),
          decode(mx, my, HA, HF, HS, VA, VF, VS, 1'b0, 1'b1));
      chk("b_x", int'(bx_o), nx);
      chk("b_y", int'(by_o), ny);
      chk("b_flags", int'({b_act, b_hs, b_vs, b_ls, b_fs}),
          decode(nx, ny, 1920, 88, 44, 1080, 4, 5, 1'b1, 1'b1));
    end
  end

  task automatic cyc(input bit r, input bit rs, input bit pe);
    reset  = r;
    resync = rs;
    pix_en = pe;
    @(posedge clk);
    #1;
  endtask

  int fs_cnt, act_cnt, hs_low, vs_hi;

  initial begin
    // Reset held three clocks with pix_en high.
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    chk("rst_x", int'(ax_o), 0);
    chk("rst_y", int'(ay_o), 0);
    chk("rst_active", int'(a_act), 1);
    chk("rst_hsync", int'(a_hs), 1);
    chk("rst_vsync", int'(a_vs), 0);
    chk("rst_line_start", int'(a_ls), 1);
    chk("rst_frame_start", int'(a_fs), 1);

    // One full frame at full rate.
    fs_cnt = 0; act_cnt = 0; hs_low = 0; vs_hi = 0;
    for (int i = 0; i < HT * VT; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      fs_cnt  += int'(a_fs);
      act_cnt += int'(a_act);
      hs_low  += int'(!a_hs);
      vs_hi   += int'(a_vs);
    end
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_active_count", act_cnt, 12);
    chk("frame_hsync_low_count", hs_low, 12);
    chk("frame_vsync_high_count", vs_hi, 8);
    chk("frame_end_x", int'(ax_o), 0);
    chk("frame_end_y", int'(ay_o), 0);

    // Half-rate enable: a frame takes 96 clocks.
    for (int i = 0; i < 94; i++) cyc(1'b0, 1'b0, (i % 2) == 0);
    chk("thr94_x", int'(ax_o), 7);
    chk("thr94_y", int'(ay_o), 5);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("thr96_x", int'(ax_o), 0);
    chk("thr96_y", int'(ay_o), 0);
    chk("thr96_fs", int'(a_fs), 1);

    // Resync from (5,2) with and without pix_en.
    repeat (21) cyc(1'b0, 1'b0, 1'b1);
    chk("pre_resync_x", int'(ax_o), 5);
    chk("pre_resync_y", int'(ay_o), 2);
    cyc(1'b0, 1'b1, 1'b1);
    chk("resync_x", int'(ax_o), 0);
    chk("resync_y", int'(ay_o), 0);
    chk("resync_fs", int'(a_fs), 1);
    repeat (21) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("resync_noen_x", int'(ax_o), 5);
    chk("resync_noen_y", int'(ay_o), 2);

    // Reset beats resync at the last pixel of the frame, pix_en low.
    repeat (26) cyc(1'b0, 1'b0, 1'b1);
    chk("last_px_x", int'(ax_o), 7);
    chk("last_px_y", int'(ay_o), 5);
    cyc(1'b1, 1'b1, 1'b0);
    chk("rstpri_x", int'(ax_o), 0);
    chk("rstpri_y", int'(ay_o), 0);
    chk("rstpri_active", int'(a_act), 1);
    chk("rstpri_hsync", int'(a_hs), 1);
    chk("rstpri_vsync", int'(a_vs), 0);
    chk("rstpri_fs", int'(a_fs), 1);

    // Random enables, resyncs and resets against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 1, $urandom_range(99) < 3, $urandom_range(99) < 70);
    end

    // Default mode: one full line at full rate reaches (0,1).
    cyc(1'b1, 1'b0, 1'b0);
    repeat (BHT) cyc(1'b0, 1'b0, 1'b1);
    chk("b_line_x", int'(bx_o), 0);
    chk("b_line_y", int'(by_o), 1);
    chk("b_line_ls", int'(b_ls), 1);
    chk("b_line_fs", int'(b_fs), 0);
    repeat (2500) cyc(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator. It replaces the single-purpose Y line counter with a combined horizontal/vertical position counter that also produces blanking, sync and frame/line markers. It sits at the front of the GPU engine pixel pipeline and drives pixel position into the layer compositor and sync/DE into the video output stage. All timing figures are parameters, so any CEA/VESA mode is a re-parameterisation with no RTL change.

## Interface
Parameters:
- `H_ACTIVE`, default 1920: visible pixels per line.
- `H_FP`, default 88: horizontal front porch, in pixels.
- `H_SYNC`, default 44: hsync width, in pixels.
- `H_BP`, default 148: horizontal back porch, in pixels.
- `V_ACTIVE`, default 1080: visible lines per frame.
- `V_FP`, default 4: vertical front porch, in lines.
- `V_SYNC`, default 5: vsync width, in lines.
- `V_BP`, default 36: vertical back porch, in lines.
- `HS_POL`, default 1: asserted level of `hsync`.
- `VS_POL`, default 1: asserted level of `vsync`.
- `X_W`, default 12: width of `x`. Must satisfy 2^X_W ≥ H_TOTAL.
- `Y_W`, default 11: width of `y`. Must satisfy 2^Y_W ≥ V_TOTAL.

Ports:
- `clk`, input, 1: single clock. Reset is synchronous and active-high.
- `reset`, input, 1: synchronous, active-high.
- `pix_en`, input, 1: pixel-rate enable. Counters advance only in cycles where this is 1.
- `resync`, input, 1: restart the frame at (0,0) on the next `pix_en`.
- `x`, output, X_W: horizontal count, 0..H_TOTAL-1.
- `y`, output, Y_W: vertical count, 0..V_TOTAL-1.
- `active`, output, 1: data enable. Asserted when x<H_ACTIVE and y<V_ACTIVE.
- `hsync`, output, 1: horizontal sync, at HS_POL level while asserted.
- `vsync`, output, 1: vertical sync, at VS_POL level while asserted.
- `line_start`, output, 1: asserted when x==0.
- `frame_start`, output, 1: asserted when x==0 and y==0.

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200 at defaults).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1125 at defaults).

Counting:
- The horizontal counter `x` increments on each `pix_en` cycle.
- At H_TOTAL-1 it wraps to 0 and generates `h_wrap`.
- The vertical counter `y` increments only on `pix_en & h_wrap`.
- At V_TOTAL-1 (together with `h_wrap`) it wraps to 0.
- With `pix_en`=0, every output holds its value.

Sync windows:
- `hsync` is asserted for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
- `vsync` is asserted for V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, for the whole line (line-aligned, not half-line).
- Outside their windows, `hsync` = ~HS_POL and `vsync` = ~VS_POL.

`resync` behaviour:
- `resync`=1 with `pix_en`=1: the next state is x=0, y=0, whatever the current position.
- `resync` has priority over the increment.
- `resync`=1 with `pix_en`=0: no effect. It is not latched.

Priority order: `reset` > `resync` > increment > hold.

## Timing
Registering and latency:
- All outputs are registered.
- Flags are computed from the next counter value and loaded in the same edge as `x`/`y`. Flags are therefore always coincident with the position they describe; there is no extra latency.
- The first `pix_en` after release takes the position from (0,0) to (1,0).

Reset:
- While `reset`=1: x=0, y=0, active=1, line_start=1, frame_start=1, hsync=~HS_POL, vsync=~VS_POL.
- These are exactly the decodes of position (0,0).
- Reset mid-frame takes effect at the next edge, regardless of `pix_en`.

Marker duration:
- `line_start` and `frame_start` are position levels, not single-clock pulses.
- Consumers qualify them with `pix_en`.
- With `pix_en` tied to 1, each is high for exactly one clock per line or per frame.

Boundary cases:
- At x=H_TOTAL-1, y=V_TOTAL-1, `pix_en`=1: the next state is (0,0) and `frame_start` rises.
- When the last active pixel is x=H_ACTIVE-1, `active` drops on the next `pix_en`.
- When H_FP=0, `hsync` rises in the same cycle that `active` falls.
- When a sync width parameter is 0, that sync output never asserts.

## Structure
- Package `video_timing_pkg` holds:
  - the 1080p60 and 720p60 parameter constants;
  - a constant function `total(active, fp, sync, bp)`;
  - a `clog2` helper for the width checks.
- Elaboration-time assertions check 2^X_W ≥ H_TOTAL and 2^Y_W ≥ V_TOTAL.
- Sub-module `wrap_counter` is parameters WIDTH, MAX with ports clk, reset, en, clr, count, wrap.
  - Instantiated twice: horizontal with en=`pix_en`; vertical with en=`pix_en & h_wrap`.
  - `clr`=`resync & pix_en` on both instances.
- Flag decode lives in the top level.

## Test plan
Bench parameters: H: 4/1/2/1 (H_TOTAL=8); V: 3/1/1/1 (V_TOTAL=6); HS_POL=0; VS_POL=1.

- **Reset:** hold `reset` 3 clocks with `pix_en`=1 → x=0, y=0, active=1, hsync=1, vsync=0, line_start=1, frame_start=1.
- **Full frame:** `pix_en`=1 for 48 clocks →
  - x runs 0..7 and y 0..5;
  - active is high for x<4 and y<3 (12 cycles per frame);
  - hsync=0 for x∈{5,6};
  - vsync=1 only for y=4;
  - frame_start is high once per 48 cycles.
- **Throttled enable:** `pix_en` alternating 1/0 → all outputs hold during 0 cycles; the frame takes 96 clocks.
- **Resync:** at x=5, y=2, assert `resync` with `pix_en`=1 → next state x=0, y=0, frame_start=1. Repeat with `pix_en`=0 → position unchanged.
- **Reset priority:** at x=7, y=5, assert `reset` and `resync` together with `pix_en`=0 → next state (0,0) with reset values.
- **Defaults:** free-run the 1080p60 defaults → 2200×1125 = 2,475,000 clocks between frame_start rises, and 2,073,600 active cycles per frame.
